// File: rtl/mem_tid_arb_pkg.sv
// mem_tid_arb_pkg: shared TID/owner types and derived sizes for the memory TID arbiter.
package mem_tid_arb_pkg;
    localparam int unsigned MemTidWidth = 2;
    localparam int unsigned NumReqCfg   = 3;
    localparam int unsigned NumTid      = 2 ** MemTidWidth;
    localparam int unsigned OwnerWidth  = $clog2(NumReqCfg);
    typedef logic [MemTidWidth-1:0] tid_t;
    typedef logic [OwnerWidth-1:0]  owner_t;
endpackage

// File: rtl/mem_tid_rr_pick.sv
// mem_tid_rr_pick: combinational round-robin picker, priority starts one past last_i.
module mem_tid_rr_pick
    import mem_tid_arb_pkg::*;
#(
    parameter int unsigned N = NumReqCfg,
    parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] valid_i,
    input  logic [W-1:0] last_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    logic [W-1:0] c;
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        c     = '0;
        any_o = |valid_i;
        // Walk from farthest to nearest so the nearest valid requester wins.
        for (int k = N; k >= 1; k--) begin
            c = W'((int'(last_i) + k) % N);
            if (valid_i[c]) begin
                gnt_o = N'(1) << c;
                idx_o = c;
            end
        end
    end
endmodule

// File: rtl/mem_tid_arbiter.sv
// mem_tid_arbiter: round-robin share of the memory request port with TID allocation
// and out-of-order response steering back to the owning requester.
module mem_tid_arbiter
    import mem_tid_arb_pkg::*;
#(
    parameter int unsigned NumReq   = NumReqCfg,
    parameter int unsigned TidWidth = MemTidWidth,
    parameter int unsigned ReqWidth = 128,
    parameter int unsigned RspWidth = 64
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NumReq-1:0]                req_valid_i,
    input  logic [NumReq-1:0][ReqWidth-1:0]  req_data_i,
    output logic [NumReq-1:0]                req_ready_o,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic [ReqWidth-1:0]              mem_req_data_o,
    output logic [TidWidth-1:0]              mem_req_tid_o,
    input  logic                             mem_rsp_valid_i,
    input  logic [TidWidth-1:0]              mem_rsp_tid_i,
    input  logic [RspWidth-1:0]              mem_rsp_data_i,
    output logic [NumReq-1:0]                rsp_valid_o,
    output logic [RspWidth-1:0]              rsp_data_o,
    output logic [TidWidth:0]                outstanding_o,
    output logic                             idle_o,
    output logic                             tid_err_o
);
    localparam int unsigned TidCnt = 2 ** TidWidth;
    localparam int unsigned OwnW   = (NumReq > 1) ? $clog2(NumReq) : 1;

    logic [TidCnt-1:0]   busy_q, busy_d;
    logic [OwnW-1:0]     owner_q [TidCnt];
    logic [OwnW-1:0]     last_q, last_d;
    logic                out_valid_q, out_valid_d;
    logic [ReqWidth-1:0] out_data_q, out_data_d;
    logic [TidWidth-1:0] out_tid_q, out_tid_d;

    logic [NumReq-1:0]   pick_oh;
    logic [OwnW-1:0]     pick_idx;
    logic                pick_any;
    logic                grant, rsp_hit;
    logic [TidWidth-1:0] alloc_tid;
    logic [TidWidth:0]   busy_cnt;

    mem_tid_rr_pick #(.N(NumReq), .W(OwnW)) u_pick (
        .valid_i (req_valid_i),
        .last_i  (last_q),
        .gnt_o   (pick_oh),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        alloc_tid = '0;
        busy_cnt  = '0;
        for (int t = TidCnt - 1; t >= 0; t--) begin
            if (!busy_q[t]) alloc_tid = TidWidth'(t);
            busy_cnt = busy_cnt + (TidWidth+1)'(busy_q[t]);
        end
        grant       = pick_any && !(&busy_q) && (!out_valid_q || mem_req_ready_i);
        rsp_hit     = mem_rsp_valid_i && busy_q[mem_rsp_tid_i];
        busy_d      = busy_q;
        // Free before alloc; alloc_tid is drawn from the pre-free bitmap so a freed ID waits a cycle.
        if (rsp_hit) busy_d[mem_rsp_tid_i] = 1'b0;
        if (grant) busy_d[alloc_tid] = 1'b1;
        last_d      = grant ? pick_idx : last_q;
        out_valid_d = grant ? 1'b1 : (mem_req_ready_i ? 1'b0 : out_valid_q);
        out_data_d  = grant ? req_data_i[pick_idx] : out_data_q;
        out_tid_d   = grant ? alloc_tid : out_tid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q      <= '0;
            last_q      <= OwnW'(NumReq - 1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tid_q   <= '0;
        end else begin
            busy_q      <= busy_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tid_q   <= out_tid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (grant) owner_q[alloc_tid] <= pick_idx;
    end

    assign req_ready_o     = grant ? pick_oh : '0;
    assign mem_req_valid_o = out_valid_q;
    assign mem_req_data_o  = out_data_q;
    assign mem_req_tid_o   = out_tid_q;
    assign rsp_valid_o     = rsp_hit ? (NumReq'(1) << owner_q[mem_rsp_tid_i]) : '0;
    assign rsp_data_o      = mem_rsp_data_i;
    assign outstanding_o   = busy_cnt;
    assign idle_o          = (busy_q == '0) && !out_valid_q;
    assign tid_err_o       = mem_rsp_valid_i && !busy_q[mem_rsp_tid_i];
endmodule

// File: tb/tb_mem_tid_arbiter.sv
// tb_mem_tid_arbiter: directed plus random stimulus against a behavioural pool/owner model.
module tb_mem_tid_arbiter;
    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [2:0]        req_valid_i;
    logic [2:0][127:0] req_data_i;
    logic [2:0]        req_ready_o;
    logic              mem_req_valid_o;
    logic              mem_req_ready_i;
    logic [127:0]      mem_req_data_o;
    logic [1:0]        mem_req_tid_o;
    logic              mem_rsp_valid_i;
    logic [1:0]        mem_rsp_tid_i;
    logic [63:0]       mem_rsp_data_i;
    logic [2:0]        rsp_valid_o;
    logic [63:0]       rsp_data_o;
    logic [2:0]        outstanding_o;
    logic              idle_o;
    logic              tid_err_o;

    mem_tid_arbiter #(.NumReq(3), .TidWidth(2), .ReqWidth(128), .RspWidth(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_data_o(mem_req_data_o), .mem_req_tid_o(mem_req_tid_o),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_tid_i(mem_rsp_tid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o), .tid_err_o(tid_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    bit           m_busy [4];
    int           m_owner[4];
    int           m_last;
    bit           m_ov;
    logic [127:0] m_od;
    int           m_ot;

    logic [2:0] c_ready, c_rsp, c_out;
    logic       c_mv, c_idle, c_err;
    logic [1:0] c_tid;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < 4; t++) m_busy[t] = 1'b0;
        m_last = 2;
        m_ov   = 1'b0;
    endtask

    task automatic step(input bit r, input logic [2:0] v, input bit mr, input bit rv, input int rt);
        int  win, ft, cnt;
        bit  g, hit;
        rst_i = r;
        req_valid_i = v;
        for (int i = 0; i < 3; i++) req_data_i[i] = {$urandom, $urandom, $urandom, $urandom};
        mem_req_ready_i = mr;
        mem_rsp_valid_i = rv;
        mem_rsp_tid_i   = 2'(rt);
        mem_rsp_data_i  = {$urandom, $urandom};
        #4;
        win = -1;
        for (int k = 1; k <= 3; k++) if (win < 0 && v[(m_last + k) % 3]) win = (m_last + k) % 3;
        ft = -1;
        cnt = 0;
        for (int t = 0; t < 4; t++) begin
            if (ft < 0 && !m_busy[t]) ft = t;
            cnt += int'(m_busy[t]);
        end
        g   = (win >= 0) && (ft >= 0) && (!m_ov || mr);
        hit = rv && m_busy[rt];
        chk("req_ready", req_ready_o, g ? 128'(1 << win) : 128'(0));
        chk("mem_req_valid", mem_req_valid_o, m_ov);
        if (m_ov) begin
            chk("mem_req_data", mem_req_data_o, m_od);
            chk("mem_req_tid", mem_req_tid_o, 128'(m_ot));
        end
        chk("rsp_valid", rsp_valid_o, hit ? 128'(1 << m_owner[rt]) : 128'(0));
        if (hit) chk("rsp_data", rsp_data_o, mem_rsp_data_i);
        chk("outstanding", outstanding_o, 128'(cnt));
        chk("idle", idle_o, (cnt == 0) && !m_ov);
        chk("tid_err", tid_err_o, rv && !m_busy[rt]);
        c_ready = req_ready_o; c_rsp = rsp_valid_o; c_out = outstanding_o;
        c_mv = mem_req_valid_o; c_idle = idle_o; c_err = tid_err_o; c_tid = mem_req_tid_o;
        if (r) model_reset();
        else begin
            if (hit) m_busy[rt] = 1'b0;
            if (g) begin
                m_busy[ft]  = 1'b1;
                m_owner[ft] = win;
                m_last      = win;
                m_ov        = 1'b1;
                m_od        = req_data_i[win];
                m_ot        = ft;
            end else if (mr) m_ov = 1'b0;
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        model_reset();
        step(1, 3'b000, 1, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        chk("lit_rst_idle", c_idle, 1);
        chk("lit_rst_mv", c_mv, 0);
        chk("lit_rst_out", c_out, 0);
        step(0, 3'b111, 1, 0, 0); chk("lit_g0", c_ready, 3'b001);
        step(0, 3'b111, 1, 0, 0); chk("lit_g1", c_ready, 3'b010); chk("lit_t0", c_tid, 0);
        step(0, 3'b111, 1, 0, 0); chk("lit_g2", c_ready, 3'b100); chk("lit_t1", c_tid, 1);
        step(0, 3'b111, 1, 0, 0); chk("lit_g3", c_ready, 3'b001); chk("lit_t2", c_tid, 2);
        step(0, 3'b111, 1, 0, 0); chk("lit_full_rdy", c_ready, 0); chk("lit_full_out", c_out, 4);
        chk("lit_t3", c_tid, 3);
        step(0, 3'b111, 1, 1, 2); chk("lit_ex_rsp", c_rsp, 3'b100); chk("lit_ex_norg", c_ready, 0);
        step(0, 3'b111, 1, 0, 0); chk("lit_ex_reg", c_ready, 3'b010); chk("lit_ex_out", c_out, 3);
        step(0, 3'b000, 1, 0, 0); chk("lit_ex_tid", c_tid, 2); chk("lit_ex_out4", c_out, 4);
        for (int t = 0; t < 4; t++) step(0, 3'b000, 1, 1, t);
        step(0, 3'b000, 1, 0, 0); chk("lit_drain_idle", c_idle, 1);
        step(0, 3'b001, 1, 0, 0); chk("lit_st_g", c_ready, 3'b001);
        for (int i = 0; i < 3; i++) begin
            step(0, 3'b001, 0, 0, 0);
            chk("lit_st_rdy", c_ready, 0); chk("lit_st_mv", c_mv, 1); chk("lit_st_tid", c_tid, 0);
        end
        step(0, 3'b001, 1, 0, 0); chk("lit_st_acc", c_ready, 3'b001); chk("lit_st_tid2", c_tid, 0);
        step(0, 3'b000, 1, 0, 0); chk("lit_st_tid1", c_tid, 1); chk("lit_st_out", c_out, 2);
        step(1, 3'b000, 1, 0, 0);
        step(0, 3'b001, 1, 0, 0);
        step(0, 3'b000, 1, 1, 1); chk("lit_err", c_err, 1); chk("lit_err_rsp", c_rsp, 0);
        chk("lit_err_out", c_out, 1);
        step(0, 3'b001, 1, 1, 0); chk("lit_sim_rdy", c_ready, 3'b001); chk("lit_sim_rsp", c_rsp, 3'b001);
        step(0, 3'b000, 1, 0, 0); chk("lit_sim_out", c_out, 1); chk("lit_sim_tid", c_tid, 1);
        for (int i = 0; i < 3; i++) step(0, 3'b111, 1, 0, 0);
        step(0, 3'b000, 0, 0, 0); chk("lit_pre_rst_mv", c_mv, 1);
        step(1, 3'b000, 0, 0, 0);
        step(0, 3'b000, 1, 0, 0);
        chk("lit_mid_idle", c_idle, 1); chk("lit_mid_mv", c_mv, 0); chk("lit_mid_out", c_out, 0);
        step(0, 3'b000, 1, 1, 2); chk("lit_late_err", c_err, 1);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, 3'($urandom), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0, int'($urandom_range(0, 3)));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
